// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle for the async FIFO: two burst writers, the RAM write port and pointer/flag exchange.
interface fifo_wr_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              last0;
  logic              last1;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W:0]   wq2_rd_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_ptr;
  logic              wr_full;
  logic              wr_afull;

  modport slave (
    input  req0, req1, data0, data1, last0, last1, wq2_rd_ptr,
    output gnt0, gnt1, wr_en, wr_addr, wr_data, wr_ptr, wr_full, wr_afull
  );

  modport master (
    output req0, req1, data0, data1, last0, last1, wq2_rd_ptr,
    input  gnt0, gnt1, wr_en, wr_addr, wr_data, wr_ptr, wr_full, wr_afull
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter onto the async FIFO write port; grant one cycle after req, then one beat/cycle.
// Beats are accepted combinationally in OWNn; registered full stalls the owner without losing its burst.
module fifo_wr_arbiter #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int AFULL_TH  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int PW   = ADDR_W + 1;
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wbin_q, wbin_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic            last_owner_q, last_owner_d;

  logic            acc0, acc1, accept;
  logic            cur_req, cur_last, cur_owner;
  logic [PW-1:0]   rbin;
  logic [PW-1:0]   full_match;
  logic [PW:0]     used, free;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    acc0   = wr_rst_n && (state_q == OWN0) && bus.req0 && !full_q;
    acc1   = wr_rst_n && (state_q == OWN1) && bus.req1 && !full_q;
    accept = acc0 | acc1;

    cur_owner = (state_q == OWN1);
    cur_req   = cur_owner ? bus.req1  : bus.req0;
    cur_last  = cur_owner ? bus.last1 : bus.last0;

    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    wbin_d       = wbin_q + {{(PW-1){1'b0}}, accept};

    case (state_q)
      IDLE: begin
        // On a tie the writer that did not own the previous burst wins.
        if (bus.req0 && (!bus.req1 || last_owner_q)) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (cur_last || (beat_cnt_q == BC_W'(MAX_BURST - 1))) begin
            state_d      = IDLE;
            last_owner_d = cur_owner;
            beat_cnt_d   = '0;
          end
        end else if (!cur_req) begin
          state_d      = IDLE;
          last_owner_d = cur_owner;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d   = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is one lap ahead: top two gray bits inverted.
    full_match = {~bus.wq2_rd_ptr[ADDR_W:ADDR_W-1], bus.wq2_rd_ptr[ADDR_W-2:0]};
    full_d     = (wr_ptr_d == full_match);

    rbin    = gray2bin(bus.wq2_rd_ptr);
    used    = {1'b0, wbin_d - rbin};
    free    = (PW+1)'(1 << ADDR_W) - used;
    afull_d = (free <= (PW+1)'(AFULL_TH));
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q      <= IDLE;
      wbin_q       <= '0;
      wr_ptr_q     <= '0;
      full_q       <= 1'b0;
      afull_q      <= 1'b0;
      beat_cnt_q   <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wbin_q       <= wbin_d;
      wr_ptr_q     <= wr_ptr_d;
      full_q       <= full_d;
      afull_q      <= afull_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.gnt0     = acc0;
  assign bus.gnt1     = acc1;
  assign bus.wr_en    = accept;
  assign bus.wr_addr  = wbin_q[ADDR_W-1:0];
  assign bus.wr_data  = (state_q == OWN1) ? bus.data1 : bus.data0;
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.wr_full  = full_q;
  assign bus.wr_afull = afull_q;
endmodule
